// File: rtl/fifo_pkg.sv
// Shared constants for the half-width-read FIFO controller.
// HALF_UPPER/HALF_LOWER name the two values of the storage half select.
package fifo_pkg;

    localparam logic HALF_UPPER = 1'b0;
    localparam logic HALF_LOWER = 1'b1;

endpackage

// File: rtl/wrap_ptr.sv
// Wrapping pointer: W-bit counter, sync active-high reset, increment enable.
// Ports: clk, reset, inc (advance by one), ptr (current value, wraps 2**W-1 -> 0).
module wrap_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_half_rd_ctrl.sv
// Pointer/flag controller: full-word writes, half-word reads (upper then lower).
// Ports: clk, reset, wr, rd in; w_en, w_addr, r_addr, same_read, empty, full, count out.
module fifo_half_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  same_read,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH+1:0] count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] words;
    logic                half;
    logic                wr_acc;
    logic                rd_acc;
    logic                rd_free;

    // Write acceptance depends only on registered state, so rd never
    // reaches w_en combinationally.
    assign wr_acc  = wr && !full;
    assign rd_acc  = rd && !empty;
    assign rd_free = rd_acc && (half == HALF_LOWER);

    assign w_en      = wr_acc;
    assign same_read = half;
    assign empty     = (words == '0);
    assign full      = (words == DEPTH_W);
    assign count     = {1'b0, words, 1'b0} - {{(ADDR_WIDTH+1){1'b0}}, half};

    wrap_ptr #(.W(ADDR_WIDTH)) u_w_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_acc),
        .ptr   (w_addr)
    );

    wrap_ptr #(.W(ADDR_WIDTH)) u_r_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_free),
        .ptr   (r_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            words <= '0;
            half  <= HALF_UPPER;
        end else begin
            if (rd_acc) begin
                half <= ~half;
            end
            unique case ({wr_acc, rd_free})
                2'b10:   words <= words + 1'b1;
                2'b01:   words <= words - 1'b1;
                default: words <= words;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_half_rd_ctrl.sv
// Self-checking bench for fifo_half_rd_ctrl (ADDR_WIDTH=2).
// Model predicts state per step; expected results queued and popped after the edge.
module tb_fifo_half_rd_ctrl;

    localparam int AW = 2;
    localparam int DEPTH = 4;

    typedef struct {
        int w_addr;
        int r_addr;
        int same_read;
        int empty;
        int full;
        int count;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          same_read;
    logic          empty;
    logic          full;
    logic [AW+1:0] count;

    int checks = 0;
    int errors = 0;

    int m_w = 0;
    int m_r = 0;
    int m_words = 0;
    int m_half = 0;

    exp_t sb[$];

    always #5 clk = ~clk;

    fifo_half_rd_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .rd        (rd),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .r_addr    (r_addr),
        .same_read (same_read),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.w_addr    = m_w;
        e.r_addr    = m_r;
        e.same_read = m_half;
        e.empty     = (m_words == 0) ? 1 : 0;
        e.full      = (m_words == DEPTH) ? 1 : 0;
        e.count     = 2 * m_words - m_half;
        return e;
    endfunction

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_w_addr"}, 32'(w_addr), e.w_addr);
        check({tag, "_r_addr"}, 32'(r_addr), e.r_addr);
        check({tag, "_same_read"}, 32'(same_read), e.same_read);
        check({tag, "_empty"}, 32'(empty), e.empty);
        check({tag, "_full"}, 32'(full), e.full);
        check({tag, "_count"}, 32'(count), e.count);
    endtask

    task automatic step(input string tag, input logic w, input logic r);
        bit wa;
        bit ra;
        wr = w;
        rd = r;
        #1;
        wa = w && (m_words < DEPTH);
        ra = r && (m_words != 0);
        check({tag, "_w_en"}, 32'(w_en), 32'(wa));
        if (ra) begin
            if (m_half == 0) begin
                m_half = 1;
            end else begin
                m_half = 0;
                m_r = (m_r + 1) % DEPTH;
                m_words--;
            end
        end
        if (wa) begin
            m_w = (m_w + 1) % DEPTH;
            m_words++;
        end
        sb.push_back(model_exp());
        @(posedge clk);
        #1;
        compare_head(tag);
    endtask

    task automatic do_reset(input string tag, input logic w, input logic r);
        reset = 1'b1;
        wr = w;
        rd = r;
        m_w = 0;
        m_r = 0;
        m_words = 0;
        m_half = 0;
        sb.push_back(model_exp());
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_head(tag);
    endtask

    initial begin
        do_reset("rst", 1'b0, 1'b0);
        check("rst_empty_k", 32'(empty), 32'd1);
        check("rst_count_k", 32'(count), 32'd0);
        step("idle", 1'b0, 1'b0);

        step("pre_w0", 1'b1, 1'b0);
        step("pre_w1", 1'b1, 1'b0);
        do_reset("rst_mid", 1'b1, 1'b1);
        check("rst_mid_w_addr_k", 32'(w_addr), 32'd0);
        check("rst_mid_count_k", 32'(count), 32'd0);

        for (int i = 0; i < 5; i++) begin
            step($sformatf("fill%0d", i), 1'b1, 1'b0);
        end
        check("fill_full_k", 32'(full), 32'd1);
        check("fill_count_k", 32'(count), 32'd8);
        check("fill_w_addr_k", 32'(w_addr), 32'd0);

        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_sel_k", i), 32'(same_read),
                  32'(i % 2));
            check($sformatf("drain%0d_raddr_k", i), 32'(r_addr),
                  32'(i / 2));
            step($sformatf("drain%0d", i), 1'b0, 1'b1);
            if (i == 1) check("drain_full_drop_k", 32'(full), 32'd0);
        end
        check("drain_empty_k", 32'(empty), 32'd1);
        step("rd_empty", 1'b0, 1'b1);
        check("rd_empty_count_k", 32'(count), 32'd0);

        step("wr_rd_empty", 1'b1, 1'b1);
        check("t4_count_k", 32'(count), 32'd2);
        check("t4_sel_k", 32'(same_read), 32'd0);

        step("t5_upper", 1'b0, 1'b1);
        check("t5_pre_count_k", 32'(count), 32'd1);
        step("t5_both", 1'b1, 1'b1);
        check("t5_count_k", 32'(count), 32'd2);
        check("t5_raddr_k", 32'(r_addr), 32'd1);
        check("t5_waddr_k", 32'(w_addr), 32'd2);

        for (int i = 0; i < 3; i++) begin
            step($sformatf("t6_fill%0d", i), 1'b1, 1'b0);
        end
        step("t6_upper", 1'b0, 1'b1);
        check("t6_pre_count_k", 32'(count), 32'd7);
        step("t6_both", 1'b1, 1'b1);
        check("t6_full_k", 32'(full), 32'd0);
        check("t6_count_k", 32'(count), 32'd6);

        for (int i = 0; i < 60; i++) begin
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
